// File: rtl/bcd_sub_ndigit_serial_pkg.sv
// Shared BCD definitions for the serial adder/subtractor/converter family:
// digit limits, the common 2-bit state encoding and a digit-validity helper.
package bcd_sub_ndigit_serial_pkg;

  localparam int BCD_MAX  = 9;
  localparam int BCD_BASE = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic digit_bad(input logic [3:0] d);
    return d > 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_sub_1digit.sv
// Combinational single-digit BCD subtractor: d = a - b - bin with decimal borrow.
// Non-BCD inputs still produce a deterministic 4-bit result and raise bad.
module bcd_sub_1digit
  import bcd_sub_ndigit_serial_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] d,
  output logic       bout,
  output logic       bad
);

  logic signed [4:0] t;

  always_comb begin
    t    = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bin});
    bout = t[4];
    // A negative raw difference wraps into the digit by adding the base
    d    = bout ? (t[3:0] + 4'(BCD_BASE)) : t[3:0];
    bad  = digit_bad(a) | digit_bad(b);
  end

endmodule

// File: rtl/bcd_sub_ndigit_serial.sv
// Multi-digit packed-BCD subtractor, one digit per clock (LS digit first).
// Start/done handshake; diff/bout/invalid update only when an operation completes.
module bcd_sub_ndigit_serial
  import bcd_sub_ndigit_serial_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  work_q;
  logic [W-1:0]  work_next;
  logic          borrow_q;
  logic          inv_acc;

  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [3:0]    d_dig;
  logic          d_bout;
  logic          d_bad;

  assign a_dig = a_q[{idx, 2'b00} +: 4];
  assign b_dig = b_q[{idx, 2'b00} +: 4];

  bcd_sub_1digit u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .bin  (borrow_q),
    .d    (d_dig),
    .bout (d_bout),
    .bad  (d_bad)
  );

  always_comb begin
    work_next = work_q;
    work_next[{idx, 2'b00} +: 4] = d_dig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      invalid  <= 1'b0;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      borrow_q <= 1'b0;
      inv_acc  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx      <= '0;
            inv_acc  <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Validity is gathered digit by digit as each operand digit passes through
          work_q   <= work_next;
          borrow_q <= d_bout;
          inv_acc  <= inv_acc | d_bad;
          idx      <= idx + 1'b1;
          if (idx == LAST) begin
            diff    <= work_next;
            bout    <= d_bout;
            invalid <= inv_acc | d_bad;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_ndigit_serial.sv
// Scoreboard bench: 4-digit and 1-digit instances, directed cases plus random
// operations against a decimal-arithmetic reference model.
module tb_bcd_sub_ndigit_serial;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, bin;
  logic [15:0] a, b;
  logic        busy, done, bout, invalid;
  logic [15:0] diff;

  logic        start1, bin1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, bout1, invalid1;
  logic [3:0]  diff1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        inv;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  bcd_sub_ndigit_serial #(.DIGITS(D)) dut4 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .invalid(invalid)
  );

  bcd_sub_ndigit_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .invalid(invalid1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain decimal arithmetic for valid operands, per-digit rule otherwise
  function automatic exp_t model(input int nd, input logic [15:0] av, input logic [15:0] bv,
                                 input logic bi);
    exp_t r;
    int   va, vb, p, v, t, br;
    logic bad;
    r.diff = '0;
    r.bout = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < nd; i++)
      if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
    r.inv = bad;
    if (!bad) begin
      va = 0; vb = 0; p = 1;
      for (int i = 0; i < nd; i++) begin
        va += int'(av[4*i +: 4]) * p;
        vb += int'(bv[4*i +: 4]) * p;
        p  *= 10;
      end
      v = va - vb - int'(bi);
      if (v < 0) begin
        v += p;
        r.bout = 1'b1;
      end
      for (int i = 0; i < nd; i++) begin
        r.diff[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end else begin
      br = int'(bi);
      for (int i = 0; i < nd; i++) begin
        t = int'(av[4*i +: 4]) - int'(bv[4*i +: 4]) - br;
        if (t < 0) begin
          t += 10;
          br = 1;
        end else begin
          br = 0;
        end
        r.diff[4*i +: 4] = 4'(t);
      end
      r.bout = br[0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      chk("done_busy_overlap4", busy, 0);
      if (q4.size() == 0) begin
        chk("unexpected_done4", done, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("diff4", diff, e.diff);
        chk("bout4", bout, e.bout);
        chk("invalid4", invalid, e.inv);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", done1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("diff1", diff1, e.diff[3:0]);
        chk("bout1", bout1, e.bout);
        chk("invalid1", invalid1, e.inv);
      end
    end
  end

  task automatic op4(input logic [15:0] av, input logic [15:0] bv, input logic bi, input exp_t e);
    int nb, lat;
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    q4.push_back(e);
    nb = 0; lat = 0;
    for (int j = 1; j <= 20 && lat == 0; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) lat = j;
      else if (busy) nb++;
    end
    chk("latency4", lat, D + 1);
    chk("busy_cycles4", nb, D);
  endtask

  task automatic op1(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    int lat;
    @(negedge clk);
    a1 = av; b1 = bv; bin1 = bi; start1 = 1'b1;
    q1.push_back(model(1, {12'h000, av}, {12'h000, bv}, bi));
    lat = 0;
    for (int j = 1; j <= 10 && lat == 0; j++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1) lat = j;
    end
    chk("latency1", lat, 2);
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic iv);
    exp_t e;
    e.diff = d; e.bout = bo; e.inv = iv;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, gap;
    logic [15:0] ra, rb;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_invalid", invalid, 0);
    rst = 1'b0;

    op4(16'h1234, 16'h0567, 1'b0, mk(16'h0667, 1'b0, 1'b0));
    op4(16'h0000, 16'h0001, 1'b0, mk(16'h9999, 1'b1, 1'b0));
    op4(16'h9999, 16'h9999, 1'b1, mk(16'h9999, 1'b1, 1'b0));
    op4(16'h00A0, 16'h0000, 1'b0, mk(16'h00A0, 1'b0, 1'b1));

    // start pulsed mid-RUN is ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h0567; bin = 1'b0; start = 1'b1;
    q4.push_back(mk(16'h0667, 1'b0, 1'b0));
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 16'h5555; b = 16'h1111;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("ignored_start_dones", cnt, 1);
    chk("ignored_start_diff", diff, 16'h0667);

    // reset during RUN: outputs clear, no done follows
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    rst = 1'b0;
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("midrst_no_done", cnt, 0);

    // start held across DONE: back-to-back with a period of D+1
    @(negedge clk);
    a = 16'h1234; b = 16'h0567; bin = 1'b0; start = 1'b1;
    q4.push_back(mk(16'h0667, 1'b0, 1'b0));
    cnt = 0;
    for (int j = 0; j < 20 && cnt == 0; j++) begin
      @(negedge clk);
      if (done) cnt = 1;
    end
    chk("b2b_first_done", cnt, 1);
    a = 16'h0100; b = 16'h0001;
    q4.push_back(mk(16'h0099, 1'b0, 1'b0));
    gap = 0;
    for (int j = 1; j <= 20 && gap == 0; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) gap = j;
    end
    chk("b2b_period", gap, D + 1);

    // random operations
    for (int n = 0; n < 40; n++) begin
      ra = '0; rb = '0;
      if (n % 5 == 4) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
      end else begin
        for (int i = 0; i < D; i++) begin
          ra[4*i +: 4] = 4'($urandom_range(0, 9));
          rb[4*i +: 4] = 4'($urandom_range(0, 9));
        end
      end
      bin = 1'($urandom);
      op4(ra, rb, bin, model(D, ra, rb, bin));
    end

    // single-digit sweep of all valid inputs
    for (int x = 0; x < 10; x++)
      for (int y = 0; y < 10; y++)
        for (int z = 0; z < 2; z++)
          op1(4'(x), 4'(y), 1'(z));

    repeat (5) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
